// File: rtl/uart_stream_pkg.sv
// uart_stream_pkg: shared state encoding and constants for the UART stream host
package uart_stream_pkg;
    typedef enum logic [1:0] {IDLE, WR, RD, SETTLE} state_e;
    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAMING = 1;
    localparam int SETTLE_W    = 4;
endpackage

// File: rtl/uart_stream_rx_buf.sv
// uart_stream_rx_buf: synchronous FIFO of received bytes with their error flags
module uart_stream_rx_buf #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [9:0]    din_i,
    input  logic          pop_i,
    output logic [9:0]    dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Storage, pointers and occupancy; a pop at full frees the slot a same-cycle push reuses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/uart_stream_host.sv
// uart_stream_host: bridges valid/ready byte streams to the CoreUART strobe interface
module uart_stream_host
    import uart_stream_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int RX_BUF_DEPTH  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic [1:0] rx_err_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       overflow_sticky_o,
    input  logic       clr_status_i,
    output logic       busy_o,
    output logic       uart_csn_o,
    output logic       uart_wen_o,
    output logic       uart_oen_o,
    output logic [7:0] uart_data_in_o,
    input  logic [7:0] uart_data_out_i,
    input  logic       uart_txrdy_i,
    input  logic       uart_rxrdy_i,
    input  logic       uart_parity_err_i,
    input  logic       uart_framing_err_i,
    input  logic       uart_overflow_i
);
    localparam int CW = $clog2(RX_BUF_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [7:0]          hold_q, hold_d, data_in_q, data_in_d;
    logic                hold_valid_q, hold_valid_d, last_rd_q, last_rd_d, sticky_q, sticky_d;
    logic                csn_q, csn_d, wen_q, wen_d, oen_q, oen_d, busy_q, busy_d;
    logic                wr_elig, rd_elig, grant_rd, grant_wr;
    logic [1:0]          rx_flags;
    logic [9:0]          buf_dout;
    logic [CW-1:0]       buf_count;
    logic                buf_full, buf_empty;

    // State register plus every flop that feeds a port, so strobes never glitch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            last_rd_q    <= 1'b0;
            sticky_q     <= 1'b0;
            csn_q        <= 1'b1;
            wen_q        <= 1'b1;
            oen_q        <= 1'b1;
            busy_q       <= 1'b0;
            data_in_q    <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            last_rd_q    <= last_rd_d;
            sticky_q     <= sticky_d;
            csn_q        <= csn_d;
            wen_q        <= wen_d;
            oen_q        <= oen_d;
            busy_q       <= busy_d;
            data_in_q    <= data_in_d;
        end
    end

    // Arbitration and next state; ties alternate, starting with a read after reset
    always_comb begin
        wr_elig      = hold_valid_q & uart_txrdy_i;
        rd_elig      = uart_rxrdy_i & (buf_count < CW'(RX_BUF_DEPTH));
        grant_rd     = rd_elig & (~wr_elig | ~last_rd_q);
        grant_wr     = wr_elig & ~grant_rd;
        state_d      = state_q;
        settle_d     = settle_q;
        last_rd_d    = last_rd_q;
        hold_valid_d = (state_q != WR) & (tx_valid_i | hold_valid_q);
        hold_d       = (tx_valid_i & ~hold_valid_q) ? tx_data_i : hold_q;
        sticky_d     = uart_overflow_i | (sticky_q & ~clr_status_i);
        case (state_q)
            IDLE: begin
                state_d   = grant_rd ? RD : grant_wr ? WR : IDLE;
                last_rd_d = (grant_rd | grant_wr) ? grant_rd : last_rd_q;
            end
            WR, RD: begin
                state_d  = SETTLE;
                settle_d = SETTLE_W'(SETTLE_CYCLES - 1);
            end
            default: begin
                state_d  = (settle_q == '0) ? IDLE : SETTLE;
                settle_d = settle_q - 1'b1;
            end
        endcase
    end

    // Strobe values for the coming cycle, decoded from the next state
    always_comb begin
        csn_d     = ~(state_d == WR || state_d == RD);
        wen_d     = state_d != WR;
        oen_d     = state_d != RD;
        busy_d    = state_d != IDLE;
        data_in_d = (state_d == WR) ? hold_q : data_in_q;
        rx_flags  = '0;
        rx_flags[ERR_PARITY]  = uart_parity_err_i;
        rx_flags[ERR_FRAMING] = uart_framing_err_i;
    end

    uart_stream_rx_buf #(.DEPTH(RX_BUF_DEPTH)) u_rx_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  ((state_q == RD) & ~buf_full),
        .din_i   ({rx_flags, uart_data_out_i}),
        .pop_i   (rx_ready_i),
        .dout_o  (buf_dout),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign tx_ready_o        = ~hold_valid_q;
    assign rx_valid_o        = ~buf_empty;
    assign rx_data_o         = buf_dout[7:0];
    assign rx_err_o          = buf_dout[9:8];
    assign overflow_sticky_o = sticky_q;
    assign busy_o            = busy_q;
    assign uart_csn_o        = csn_q;
    assign uart_wen_o        = wen_q;
    assign uart_oen_o        = oen_q;
    assign uart_data_in_o    = data_in_q;
endmodule

// File: tb/tb_uart_stream_host.sv
// tb_uart_stream_host: directed scoreboard bench for the UART stream host
module tb_uart_stream_host;
    logic       clk = 1'b0;
    logic       rst, tx_valid, tx_ready, rx_valid, rx_ready, sticky, clr, busy;
    logic       csn, wen, oen, txrdy, rxrdy, perr, ferr, ovf;
    logic [7:0] tx_data, rx_data, data_in, data_out;
    logic [1:0] rx_err;

    int         checks = 0, errors = 0, nwr = 0, nrd = 0, cyc_n = 0;
    logic [7:0] wr_exp[$];
    logic [9:0] rx_exp[$];
    bit         acc_is_rd[$];
    int         acc_cyc[$];
    bit         rd_pending = 0, acc_last = 0;

    always #5 clk = ~clk;

    uart_stream_host dut (
        .clk_i(clk), .rst_i(rst),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_err_o(rx_err), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .overflow_sticky_o(sticky), .clr_status_i(clr), .busy_o(busy),
        .uart_csn_o(csn), .uart_wen_o(wen), .uart_oen_o(oen),
        .uart_data_in_o(data_in), .uart_data_out_i(data_out),
        .uart_txrdy_i(txrdy), .uart_rxrdy_i(rxrdy),
        .uart_parity_err_i(perr), .uart_framing_err_i(ferr), .uart_overflow_i(ovf)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: consumer check before the edge, then sample strobes 1 time unit after it
    task automatic cyc();
        logic       acc;
        logic [9:0] head;
        acc = tx_valid && tx_ready;
        if (rx_valid && rx_ready) begin
            chk("rx_sb_nonempty", 32'(rx_exp.size() > 0), 1);
            if (rx_exp.size() > 0) begin
                head = rx_exp.pop_front();
                chk("rx_data", 32'(rx_data), 32'(head[7:0]));
                chk("rx_err", 32'(rx_err), 32'(head[9:8]));
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        acc_last = acc;
        if (acc) wr_exp.push_back(tx_data);
        if (rd_pending) begin
            data_out   = data_out + 8'h01;
            rd_pending = 0;
        end
        if (!csn && !wen) begin
            nwr++;
            acc_is_rd.push_back(0);
            acc_cyc.push_back(cyc_n);
            chk("wr_sb_nonempty", 32'(wr_exp.size() > 0), 1);
            if (wr_exp.size() > 0) chk("wr_data", 32'(data_in), 32'(wr_exp.pop_front()));
        end
        if (!csn && !oen) begin
            nrd++;
            acc_is_rd.push_back(1);
            acc_cyc.push_back(cyc_n);
            rx_exp.push_back({ferr, perr, data_out});
            rd_pending = 1;
        end
    endtask

    initial begin
        rst = 1; tx_data = 0; tx_valid = 0; rx_ready = 0; clr = 0; data_out = 0;
        txrdy = 0; rxrdy = 0; perr = 0; ferr = 0; ovf = 0;
        cyc(); cyc();
        chk("rst_csn", 32'(csn), 1);
        chk("rst_wen", 32'(wen), 1);
        chk("rst_oen", 32'(oen), 1);
        chk("rst_data_in", 32'(data_in), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_err", 32'(rx_err), 0);
        chk("rst_sticky", 32'(sticky), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        rst = 0;
        // reset in the middle of a read access
        rxrdy = 1; data_out = 8'h77;
        cyc();
        chk("rd_pre_rst_oen", 32'(oen), 0);
        chk("rd_pre_rst_csn", 32'(csn), 0);
        rst = 1;
        #1;
        chk("rst_async_csn", 32'(csn), 1);
        chk("rst_async_oen", 32'(oen), 1);
        chk("rst_async_wen", 32'(wen), 1);
        cyc();
        rxrdy = 0; rst = 0;
        cyc();
        chk("post_rst_rx_valid", 32'(rx_valid), 0);
        chk("post_rst_tx_ready", 32'(tx_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        rx_exp.delete();
        nwr = 0; nrd = 0;
        // single write of A5
        txrdy = 1; tx_data = 8'hA5; tx_valid = 1;
        cyc();
        tx_valid = 0;
        chk("tx_accept", 32'(acc_last), 1);
        chk("tx_ready_full", 32'(tx_ready), 0);
        cyc();
        chk("wr_csn", 32'(csn), 0);
        chk("wr_wen", 32'(wen), 0);
        chk("wr_oen", 32'(oen), 1);
        chk("wr_data_in", 32'(data_in), 'hA5);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("settle_csn", 32'(csn), 1);
            chk("settle_busy", 32'(busy), 1);
        end
        cyc();
        chk("idle_busy", 32'(busy), 0);
        chk("wr_count", nwr, 1);
        chk("wr_sb_drained", wr_exp.size(), 0);
        chk("tx_ready_free", 32'(tx_ready), 1);
        // single read of 3C with parity error
        rxrdy = 1; data_out = 8'h3C; perr = 1;
        cyc();
        chk("rd_oen", 32'(oen), 0);
        chk("rd_wen", 32'(wen), 1);
        cyc();
        rxrdy = 0; perr = 0;
        chk("rx_valid_lat", 32'(rx_valid), 1);
        chk("rx_data_3c", 32'(rx_data), 'h3C);
        chk("rx_err_parity", 32'(rx_err), 'b01);
        rx_ready = 1;
        cyc();
        rx_ready = 0;
        chk("rx_popped", 32'(rx_valid), 0);
        cyc(); cyc(); cyc();
        // buffer backpressure
        nrd = 0; rxrdy = 1; ferr = 1; data_out = 8'h40;
        for (int i = 0; i < 20; i++) cyc();
        chk("rd_full_count", nrd, 2);
        chk("rx_full_valid", 32'(rx_valid), 1);
        rx_ready = 1;
        cyc();
        rx_ready = 0;
        for (int i = 0; i < 20; i++) cyc();
        chk("rd_after_pop", nrd, 3);
        rxrdy = 0; rx_ready = 1;
        for (int i = 0; i < 6; i++) cyc();
        rx_ready = 0;
        chk("rx_drained", 32'(rx_valid), 0);
        chk("rx_sb_drained", rx_exp.size(), 0);
        // round-robin between reads and writes
        ferr = 0; rst = 1;
        cyc();
        rst = 0; nwr = 0; nrd = 0;
        txrdy = 0; tx_data = 8'h10; tx_valid = 1;
        cyc();
        tx_valid = 0; tx_data = 8'h11;
        chk("hold_loaded", 32'(tx_ready), 0);
        cyc();
        chk("no_wr_txrdy0", 32'(wen), 1);
        acc_is_rd.delete();
        acc_cyc.delete();
        rxrdy = 1; txrdy = 1; rx_ready = 1; tx_valid = 1; data_out = 8'h80;
        for (int i = 0; i < 18; i++) begin
            cyc();
            if (acc_last) tx_data = tx_data + 8'h01;
        end
        rxrdy = 0; tx_valid = 0; txrdy = 0;
        chk("alt_count", acc_is_rd.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < acc_is_rd.size()) chk("alt_kind", 32'(acc_is_rd[i]), 32'(i % 2 == 0));
        for (int i = 1; i < 4; i++)
            if (i < acc_cyc.size()) chk("alt_gap", acc_cyc[i] - acc_cyc[i-1], 5);
        chk("alt_writes", nwr, 2);
        // overflow sticky and stalled transmitter
        ovf = 1; clr = 1;
        cyc();
        ovf = 0;
        chk("sticky_set_wins", 32'(sticky), 1);
        cyc();
        clr = 0;
        chk("sticky_cleared", 32'(sticky), 0);
        ovf = 1;
        cyc();
        ovf = 0;
        chk("sticky_set", 32'(sticky), 1);
        cyc();
        chk("sticky_holds", 32'(sticky), 1);
        clr = 1;
        cyc();
        clr = 0;
        chk("sticky_clr", 32'(sticky), 0);
        for (int i = 0; i < 30; i++) cyc();
        chk("txrdy0_no_wen", nwr, 2);
        chk("txrdy0_tx_ready", 32'(tx_ready), 0);
        chk("txrdy0_hold_pending", wr_exp.size(), 1);
        chk("txrdy0_idle", 32'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
